// File: rtl/threshold_dac_ctl.sv
// threshold_dac_ctl: writes a 16-bit comparator threshold to the DAC as a 24-bit SPI frame {DAC_CMD, code}, then waits for settling.
// Latency: threshold_rdy_o rises 50*CLK_DIV+SETTLE_CYCLES cycles after the accept edge; outputs are registered.
// Backpressure: requests are ignored while threshold_rdy_o=0. Option macro THRESHOLD_SKIP_SAME_EN skips rewriting an unchanged code.
module threshold_dac_ctl #(
  parameter int         CLK_DIV       = 2,
  parameter int         SETTLE_CYCLES = 100,
  parameter logic [7:0] DAC_CMD       = 8'h30
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic [15:0] threshold_i,
  input  logic        threshold_wre_i,
  output logic        threshold_rdy_o,
  output logic [15:0] threshold_o,
  output logic        dac_sync_n_o,
  output logic        dac_sclk_o,
  output logic        dac_sdin_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SHIFT,
    ST_GAP,
    ST_SETTLE
  } state_t;

  localparam logic [7:0]  DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_div;
  logic [7:0]  w_div_nxt;
  logic [4:0]  r_bit;
  logic [4:0]  w_bit_nxt;
  logic        r_high;
  logic        w_high_nxt;
  logic [15:0] r_settle;
  logic [15:0] w_settle_nxt;
  logic [23:0] r_shift;
  logic [23:0] w_shift_nxt;
  logic [15:0] r_code;
  logic [15:0] w_code_nxt;
  logic        r_done;
  logic [15:0] r_thr;
  logic        r_rdy;
  logic        r_sync_n;
  logic        r_sclk;
  logic        r_sdin;
  logic        w_div_done;
  logic        w_in_frame;
  logic        w_gap_entry;

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_high   <= 1'b0;
      r_settle <= '0;
      r_shift  <= '0;
      r_code   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_bit    <= w_bit_nxt;
      r_high   <= w_high_nxt;
      r_settle <= w_settle_nxt;
      r_shift  <= w_shift_nxt;
      r_code   <= w_code_nxt;
    end
  end

  // Next-state logic: frame sequencing, SCLK half-period timing and settle countdown.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bit_nxt    = r_bit;
    w_high_nxt   = r_high;
    w_settle_nxt = r_settle;
    w_shift_nxt  = r_shift;
    w_code_nxt   = r_code;
    w_div_done   = (r_div == DIV_LAST);
    case (r_state)
      ST_IDLE: begin
        if (threshold_wre_i && r_rdy) begin
          w_code_nxt  = threshold_i;
          w_shift_nxt = {DAC_CMD, threshold_i};
          w_div_nxt   = '0;
`ifdef THRESHOLD_SKIP_SAME_EN
          // An unchanged code only needs a one-cycle busy pulse, no SPI traffic.
          if (r_done && (threshold_i == r_thr)) begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = '0;
          end else begin
            w_state_nxt = ST_SYNC;
          end
`else
          w_state_nxt = ST_SYNC;
`endif
        end
      end
      ST_SYNC: begin
        if (w_div_done) begin
          w_state_nxt = ST_SHIFT;
          w_div_nxt   = '0;
          w_bit_nxt   = 5'd23;
          w_high_nxt  = 1'b0;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (!w_div_done) begin
          w_div_nxt = r_div + 8'd1;
        end else begin
          w_div_nxt = '0;
          if (!r_high) begin
            // SCLK rises: present the next bit so it is stable at the next falling edge.
            w_high_nxt  = 1'b1;
            w_shift_nxt = {r_shift[22:0], 1'b0};
          end else if (r_bit == 5'd0) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_bit_nxt  = r_bit - 5'd1;
            w_high_nxt = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (w_div_done) begin
          w_div_nxt = '0;
          if (SETTLE_CYCLES == 0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = SETTLE_LOAD;
          end
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (r_settle == 16'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_settle_nxt = r_settle - 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_in_frame  = (w_state_nxt == ST_SYNC) || (w_state_nxt == ST_SHIFT);
  assign w_gap_entry = (w_state_nxt == ST_GAP) && (r_state != ST_GAP);

  // Registered outputs derived from the next state so they line up with the state register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rdy    <= 1'b1;
      r_sync_n <= 1'b1;
      r_sclk   <= 1'b1;
      r_sdin   <= 1'b0;
      r_thr    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_rdy    <= (w_state_nxt == ST_IDLE);
      r_sync_n <= !w_in_frame;
      r_sclk   <= !((w_state_nxt == ST_SHIFT) && !w_high_nxt);
      r_sdin   <= w_in_frame ? w_shift_nxt[23] : 1'b0;
      if (w_gap_entry) begin
        r_thr  <= r_code;
        r_done <= 1'b1;
      end
    end
  end

  assign threshold_rdy_o = r_rdy;
  assign threshold_o     = r_thr;
  assign dac_sync_n_o    = r_sync_n;
  assign dac_sclk_o      = r_sclk;
  assign dac_sdin_o      = r_sdin;

endmodule
